// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator for the 6502 core.
// Produces the value the register file loads into pc on every edge. It covers
// the two-byte reset-vector fetch, sequential increment, absolute jumps and
// relative branches.
// Build option: define PC_BRANCH_PENALTY_EN to get the 6502 page-crossing
// fix-up cycle (BR_FIX). Without it, every taken branch resolves in one cycle.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic [2:0]  cmd,
  input  logic        br_taken,
  input  logic [7:0]  rel_offset,
  input  logic [15:0] jmp_target,
  input  logic [7:0]  vec_data,
  output logic        vec_rd,
  output logic [15:0] vec_addr,
  output logic [15:0] next_pc,
  output logic        stall
);

  localparam logic [2:0]  CMD_INC    = 3'd1;
  localparam logic [2:0]  CMD_BRANCH = 3'd2;
  localparam logic [2:0]  CMD_JUMP   = 3'd3;
  localparam logic [15:0] RV_HI      = RESET_VECTOR + 16'd1;

`ifdef PC_BRANCH_PENALTY_EN
  typedef enum logic [1:0] {RST_LO, RST_HI, RUN, BR_FIX} state_t;
`else
  typedef enum logic [1:0] {RST_LO, RST_HI, RUN} state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_lo_byte;
  logic [15:0] w_target;
`ifdef PC_BRANCH_PENALTY_EN
  logic [15:0] r_fix_pc;
  logic        w_page_cross;
`endif

  // Branch target: pc_in already points past the offset byte; carry-out dropped.
  assign w_target = pc_in + {{8{rel_offset[7]}}, rel_offset};
`ifdef PC_BRANCH_PENALTY_EN
  // A wrap across FFFF/0000 also changes the high byte, so it counts as a cross.
  assign w_page_cross = (w_target[15:8] != pc_in[15:8]);
`endif

  // Sequencer state: vector fetch, then run; optional fix-up after page cross.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_LO;
      r_lo_byte <= 8'h00;
`ifdef PC_BRANCH_PENALTY_EN
      r_fix_pc  <= 16'h0000;
`endif
    end else begin
      case (r_state)
        RST_LO: begin
          r_lo_byte <= vec_data;
          r_state   <= RST_HI;
        end
        RST_HI: r_state <= RUN;
        RUN: begin
          r_state <= RUN;
`ifdef PC_BRANCH_PENALTY_EN
          if (cmd == CMD_BRANCH && br_taken && w_page_cross) begin
            r_fix_pc <= w_target;
            r_state  <= BR_FIX;
          end
`endif
        end
`ifdef PC_BRANCH_PENALTY_EN
        BR_FIX: r_state <= RUN;
`endif
        default: r_state <= RST_LO;
      endcase
    end
  end

  // Output decode: combinational from state, registered bytes and current inputs.
  always_comb begin
    vec_rd   = 1'b0;
    vec_addr = 16'h0000;
    stall    = 1'b0;
    next_pc  = pc_in;
    case (r_state)
      RST_LO: begin
        vec_rd   = 1'b1;
        vec_addr = RESET_VECTOR;
        stall    = 1'b1;
        next_pc  = RESET_VECTOR;
      end
      RST_HI: begin
        vec_rd   = 1'b1;
        vec_addr = RV_HI;
        stall    = 1'b1;
        next_pc  = {vec_data, r_lo_byte};
      end
      RUN: begin
        case (cmd)
          CMD_INC:  next_pc = pc_in + 16'd1;
          CMD_JUMP: next_pc = jmp_target;
          CMD_BRANCH: begin
            if (br_taken) begin
`ifdef PC_BRANCH_PENALTY_EN
              // On a page cross the old high byte is kept for one cycle.
              next_pc = w_page_cross ? {pc_in[15:8], w_target[7:0]} : w_target;
`else
              next_pc = w_target;
`endif
            end
          end
          default: next_pc = pc_in;
        endcase
      end
`ifdef PC_BRANCH_PENALTY_EN
      BR_FIX: begin
        stall   = 1'b1;
        next_pc = r_fix_pc;
      end
`endif
      default: begin
        vec_rd   = 1'b0;
        vec_addr = 16'h0000;
        stall    = 1'b0;
        next_pc  = pc_in;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: the bench plays the register file and the vector
// memory, predicts each cycle's outputs from the sequencer's rules, queues the
// prediction, and a negedge monitor compares the DUT against the queue.
`timescale 1ns/1ps
module tb_pc_sequencer;

`ifdef PC_BRANCH_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in;
  logic [2:0]  cmd;
  logic        br_taken;
  logic [7:0]  rel_offset;
  logic [15:0] jmp_target;
  logic [7:0]  vec_data;
  logic        vec_rd;
  logic [15:0] vec_addr;
  logic [15:0] next_pc;
  logic        stall;

  logic [15:0] rf_pc = 16'h0000;
  logic        force_en;
  logic [15:0] force_val;
  logic [7:0]  vec_lo;
  logic [7:0]  vec_hi;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .cmd        (cmd),
    .br_taken   (br_taken),
    .rel_offset (rel_offset),
    .jmp_target (jmp_target),
    .vec_data   (vec_data),
    .vec_rd     (vec_rd),
    .vec_addr   (vec_addr),
    .next_pc    (next_pc),
    .stall      (stall)
  );

  // Register file: loads next_pc every edge; the bench may override pc for a cycle.
  always @(posedge clk) rf_pc <= next_pc;
  assign pc_in = force_en ? force_val : rf_pc;

  // Vector memory: two bytes at FFFC/FFFD, answered in the same cycle.
  assign vec_data = (vec_addr == 16'hFFFC) ? vec_lo :
                    ((vec_addr == 16'hFFFD) ? vec_hi : 8'h00);

  typedef struct packed {
    logic [15:0] npc;
    logic        stall;
    logic        vrd;
    logic [15:0] vaddr;
    logic        chk_pc;
    logic [15:0] pc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  pend_q[$];
  string pend_tag[$];

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] mpc    = 16'h0000;

  function automatic exp_t mk(input logic [15:0] npc, input logic st,
                              input logic rd, input logic [15:0] va);
    exp_t e;
    e.npc    = npc;
    e.stall  = st;
    e.vrd    = rd;
    e.vaddr  = va;
    e.chk_pc = 1'b0;
    e.pc     = 16'h0000;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] expv);
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, expv);
    end
  endtask

  // Monitor: every cycle with a pending prediction, compare the DUT outputs.
  exp_t  mon_e;
  string mon_nm;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e  = sb_q.pop_front();
      mon_nm = tag_q.pop_front();
      n_vec++;
      chk(mon_nm, "next_pc",  next_pc, mon_e.npc);
      chk(mon_nm, "stall",    {15'b0, stall},  {15'b0, mon_e.stall});
      chk(mon_nm, "vec_rd",   {15'b0, vec_rd}, {15'b0, mon_e.vrd});
      chk(mon_nm, "vec_addr", vec_addr, mon_e.vaddr);
      if (mon_e.chk_pc) chk(mon_nm, "pc", pc_in, mon_e.pc);
    end
  end

  // One cycle of stimulus; the prediction comes from pending work or the command.
  task automatic step(input string nm, input logic [2:0] c, input logic b,
                      input logic [7:0] off, input logic [15:0] tgt,
                      input logic fe, input logic [15:0] fv);
    exp_t        e;
    exp_t        fx;
    string       n2;
    logic [15:0] p;
    logic [15:0] t;
    @(posedge clk); #1;
    cmd        = c;
    br_taken   = b;
    rel_offset = off;
    jmp_target = tgt;
    force_en   = fe;
    force_val  = fv;
    p = fe ? fv : mpc;
    if (pend_q.size() > 0) begin
      e  = pend_q.pop_front();
      n2 = pend_tag.pop_front();
      if (e.chk_pc) e.pc = p;
    end else begin
      e        = mk(p, 1'b0, 1'b0, 16'h0000);
      e.chk_pc = 1'b1;
      e.pc     = p;
      n2       = nm;
      if (c == 3'd1) e.npc = 16'(int'(p) + 1);
      else if (c == 3'd3) e.npc = tgt;
      else if (c == 3'd2 && b) begin
        t = 16'(int'(p) + int'($signed(off)));
        if (PENALTY && ((t >> 8) != (p >> 8))) begin
          e.npc     = {p[15:8], t[7:0]};
          fx        = mk(t, 1'b1, 1'b0, 16'h0000);
          fx.chk_pc = 1'b1;
          pend_q.push_back(fx);
          pend_tag.push_back({nm, "_fix"});
        end else begin
          e.npc = t;
        end
      end
    end
    mpc = e.npc;
    sb_q.push_back(e);
    tag_q.push_back(n2);
  endtask

  // Assert reset mid-cycle, hold one cycle, release and queue the vector fetch.
  task automatic do_reset(input logic [7:0] lo, input logic [7:0] hi);
    exp_t e;
    @(posedge clk); #1;
    rst_n    = 1'b0;
    force_en = 1'b0;
    pend_q.delete();
    pend_tag.delete();
    e = mk(16'hFFFC, 1'b1, 1'b1, 16'hFFFC);
    sb_q.push_back(e);
    tag_q.push_back("rst_lo_async");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    vec_lo = lo;
    vec_hi = hi;
    sb_q.push_back(e);
    tag_q.push_back("rst_lo");
    pend_q.push_back(mk({hi, lo}, 1'b1, 1'b1, 16'hFFFD));
    pend_tag.push_back("rst_hi");
    mpc = 16'hFFFC;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  logic [2:0]  r_c;
  logic [7:0]  r_off;
  logic [15:0] r_tgt;
  logic [15:0] r_fv;
  int          r_sel;

  initial begin
    rst_n      = 1'b0;
    cmd        = 3'd0;
    br_taken   = 1'b0;
    rel_offset = 8'h00;
    jmp_target = 16'h0000;
    force_en   = 1'b0;
    force_val  = 16'h0000;
    vec_lo     = 8'h00;
    vec_hi     = 8'h00;

    do_reset(8'h34, 8'h12);
    step("rst_hi",      3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("pc_1234",     3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("inc",         3'd1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("inc_wrap",    3'd1, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hFFFF);
    step("after_wrap",  3'd1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("br_same",     3'd2, 1'b1, 8'hF0, 16'h0000, 1'b1, 16'h1210);
    step("br_not",      3'd2, 1'b0, 8'hF0, 16'h0000, 1'b1, 16'h1210);
    step("br_cross",    3'd2, 1'b1, 8'h20, 16'h0000, 1'b1, 16'h12F0);
    step("fix_jmp_ign", 3'd3, 1'b0, 8'h00, 16'hC000, 1'b0, 16'h0000);
    step("after_cross", 3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("jump",        3'd3, 1'b0, 8'h00, 16'hC000, 1'b0, 16'h0000);
    step("after_jump",  3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    for (int i = 4; i < 8; i++)
      step("cmd_hold_alias", 3'(i), 1'b1, 8'h10, 16'h4000, 1'b0, 16'h0000);
    step("br_wrap_up",  3'd2, 1'b1, 8'h20, 16'h0000, 1'b1, 16'hFFF0);
    step("wrap_up_nx",  3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("br_wrap_dn",  3'd2, 1'b1, 8'hF0, 16'h0000, 1'b1, 16'h0005);
    step("wrap_dn_nx",  3'd1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    step("wrap_dn_nx2", 3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);

    step("br_cross2",   3'd2, 1'b1, 8'h40, 16'h0000, 1'b1, 16'h20E0);
    do_reset(8'hA5, 8'h5A);
    step("rst_hi2",     3'd3, 1'b0, 8'h00, 16'h1111, 1'b0, 16'h0000);
    step("pc_5AA5",     3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      r_sel = int'($urandom_range(0, 99));
      r_c   = 3'($urandom_range(0, 7));
      r_off = 8'($urandom);
      r_tgt = 16'($urandom);
      r_fv  = 16'($urandom);
      if (r_sel < 2) do_reset(8'($urandom), 8'($urandom));
      else step("rand", r_c, 1'($urandom), r_off, r_tgt, (r_sel < 15), r_fv);
    end

    for (int i = 0; i < 3; i++)
      step("drain", 3'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generator for the 6502 core. It sits directly upstream of the register file and drives that block's `next_pc` input, which the register file loads into `pc` on every rising edge. It handles:
- the reset-vector fetch;
- sequential increment;
- absolute jumps;
- relative branches, including the 6502 page-crossing fix-up cycle.

## Interface
Parameters:
- `RESET_VECTOR`, default 16'hFFFC: address of the vector low byte; high byte is at `RESET_VECTOR+1`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_in`  in  16  current `pc` from the register file.
- `cmd`  in  3  3'd0 HOLD, 3'd1 INC, 3'd2 BRANCH, 3'd3 JUMP; 3'd4–7 are treated as HOLD.
- `br_taken`  in  1  branch condition result; sampled only with BRANCH.
- `rel_offset`  in  8  signed branch displacement (two's complement).
- `jmp_target`  in  16  absolute target for JUMP.
- `vec_data`  in  8  byte read from memory at `vec_addr`; valid in the same cycle.
- `vec_rd`  out  1  vector read request.
- `vec_addr`  out  16  vector read address.
- `next_pc`  out  16  value the register file loads into `pc` at the next edge.
- `stall`  out  1  sequencer busy; the control unit must not advance and `cmd` is ignored.

## Operation
States: `RST_LO`, `RST_HI`, `RUN`, `BR_FIX`.

Reset behaviour:
- Reset is asynchronous: state returns to `RST_LO` immediately on `rst_n` low, including mid-branch.
- While reset is asserted, the `lo_byte` and `fix_pc` registers clear to 0.

`RST_LO`:
- Outputs: `vec_rd`=1, `vec_addr`=`RESET_VECTOR`, `stall`=1, `next_pc`=`RESET_VECTOR`.
- On an edge with `rst_n` high: `lo_byte` <= `vec_data`, go to `RST_HI`.

`RST_HI`:
- Outputs: `vec_rd`=1, `vec_addr`=`RESET_VECTOR+1`, `stall`=1, `next_pc`={`vec_data`,`lo_byte`}.
- Next state: `RUN`.

`RUN`, with `vec_rd`=0, `vec_addr`=0, `stall`=0:
- HOLD: `next_pc`=`pc_in`.
- INC: `next_pc`=`pc_in`+1, mod 2^16 (16'hFFFF -> 16'h0000).
- JUMP: `next_pc`=`jmp_target`.
- BRANCH, `br_taken`=0: `next_pc`=`pc_in`.
- BRANCH, `br_taken`=1: `target`=`pc_in` + sign-extended `rel_offset`, mod 2^16. `pc_in` already points past the offset byte; the control unit guarantees this.
  - Same page (`target[15:8]`==`pc_in[15:8]`): `next_pc`=`target`; stay in `RUN`.
  - Page cross: `next_pc`={`pc_in[15:8]`,`target[7:0]`}; `fix_pc` <= `target`; go to `BR_FIX`.

`BR_FIX`:
- Outputs: `stall`=1, `next_pc`=`fix_pc`.
- `cmd` is ignored.
- Next state: `RUN`.

Datapath rules:
- All address arithmetic is 16-bit with carry-out discarded.
- Page cross is judged on bits [15:8] only; a wrap across 16'hFFFF/16'h0000 counts as a page cross.

## Timing
- `next_pc`, `vec_rd`, `vec_addr` and `stall` are combinational from state, registered values and current inputs. No path runs from `next_pc` back into the sequencer inside one cycle; `pc_in` is registered in the register file.
- Reset release to first fetch PC: 2 edges. Edge 1 leaves `RST_LO`; edge 2 loads the vector into `pc`, and `RUN` begins.
- INC, JUMP, HOLD and same-page taken branch: 1 cycle; `pc` updates at the next edge.
- Page-crossing taken branch: 2 cycles. The intermediate `pc` is visible for exactly one cycle; `stall`=1 during the second cycle.
- Reset asserted during `BR_FIX`: the fix-up is abandoned and the vector fetch restarts from `RST_LO`.

## Configuration
`PC_BRANCH_PENALTY_EN`:
- Defined: page-crossing branches take the two-cycle `BR_FIX` path described above, cycle-accurate to the 6502.
- Undefined:
  - Every taken branch completes in one cycle with `next_pc`=`target`.
  - The `BR_FIX` state and `fix_pc` register are not built.
  - `stall` is asserted only in `RST_LO`/`RST_HI`.

## Test plan
- Reset vector: assert `rst_n`=0, then release; drive `vec_data`=8'h34 for 16'hFFFC and 8'h12 for 16'hFFFD. Required: `vec_addr` sequence FFFC then FFFD; `stall` high for 2 cycles; `pc`=16'h1234 after edge 2.
- Increment wrap: `pc_in`=16'hFFFF, `cmd`=INC. Required: `next_pc`=16'h0000, `stall`=0.
- Same-page branch: `pc_in`=16'h1210, `rel_offset`=8'hF0, `br_taken`=1. Required: `next_pc`=16'h1200 in one cycle; not-taken variant gives `next_pc`=16'h1210.
- Page-cross branch (`PC_BRANCH_PENALTY_EN` defined): `pc_in`=16'h12F0, `rel_offset`=8'h20. Required: `next_pc`=16'h1210, then 16'h1310 with `stall`=1; a JUMP issued during `BR_FIX` is ignored. With the macro undefined: `next_pc`=16'h1310 in one cycle and `stall`=0.
- Reset mid-fix-up: enter `BR_FIX`, then pull `rst_n` low asynchronously mid-cycle. Required: `stall`=1, `vec_addr`=16'hFFFC and `next_pc`=16'hFFFC immediately, with no edge needed.
- Jump: `cmd`=JUMP, `jmp_target`=16'hC000. Required: `pc`=16'hC000 after one edge.
